// File: rtl/overflow_counter_pkg.sv
// Shared defaults for the overflow-counter clock divider, plus a divide-ratio helper.
package overflow_counter_pkg;

  localparam int unsigned DEF_COUNT_WIDTH = 4;
  localparam longint      DEF_TERMINAL    = (longint'(1) << DEF_COUNT_WIDTH) - 1;

  // dividedClk period in clk cycles for a given terminal count.
  function automatic longint divide_ratio(input longint terminal);
    return 2 * (terminal + 1);
  endfunction

endpackage

// File: rtl/overflow_counter_wrap_counter.sv
// Enable-gated wrap-around counter: counts 0..TERM and flags the edge on which it wraps.
module wrap_counter
  import overflow_counter_pkg::*;
#(
  parameter int unsigned              COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter logic [COUNT_WIDTH-1:0]   TERM        = '1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   wrap_o
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   at_term;

  always_comb begin
    at_term = (count_q == TERM);
    // A wrap coinciding with reset is discarded.
    wrap_o  = en_i & at_term & ~rst_i;
    count_d = count_q;
    if (en_i) begin
      count_d = at_term ? '0 : count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/overflow_counter.sv
// Clock divider: toggles dividedClk and pulses overflow each time the wrap counter rolls over.
module overflow_counter
  import overflow_counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter longint      TERMINAL    = (longint'(1) << COUNT_WIDTH) - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   dividedClk,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  if (COUNT_WIDTH < 1 || COUNT_WIDTH > 32) begin : g_width_err
    $error("overflow_counter: COUNT_WIDTH must be in 1..32");
  end
  if (TERMINAL < 1 || TERMINAL > ((longint'(1) << COUNT_WIDTH) - 1)) begin : g_term_err
    $error("overflow_counter: TERMINAL must be in 1..2**COUNT_WIDTH-1");
  end

  localparam logic [COUNT_WIDTH-1:0] TERM_C = TERMINAL[COUNT_WIDTH-1:0];

  logic wrap;
  logic div_q, div_d;
  logic ovf_q, ovf_d;

  wrap_counter #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .TERM        (TERM_C)
  ) u_wrap_counter (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (enable),
    .count_o (count),
    .wrap_o  (wrap)
  );

  always_comb begin
    div_d = div_q ^ wrap;
    ovf_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  assign dividedClk = div_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_overflow_counter.sv
// Bench for overflow_counter: default instance via a vector table, a 3-bit/TERMINAL=4 instance by hand.
module tb_overflow_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       div_a, ovf_a;
  logic [3:0] cnt_a;
  logic       div_b, ovf_b;
  logic [2:0] cnt_b;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  overflow_counter u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .dividedClk (div_a),
    .count      (cnt_a),
    .overflow   (ovf_a)
  );

  overflow_counter #(.COUNT_WIDTH(3), .TERMINAL(4)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .dividedClk (div_b),
    .count      (cnt_b),
    .overflow   (ovf_b)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] cnt;
    logic       div;
    logic       ovf;
  } vec_t;

  localparam int NV = 52;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 ns later.
  task automatic step(input logic r, input logic e);
    reset  = r;
    enable = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;

    // Reset with enable low, then reset+enable (reset wins), then free-run 40 edges.
    for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    for (int i = 10; i < 12; i++) vecs[i] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    for (int k = 1; k <= 40; k++) begin
      vecs[11+k] = '{1'b0, 1'b1, 4'(k % 16), 1'((k / 16) % 2), 1'(k % 16 == 0)};
    end

    reset  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].en);
      check($sformatf("vec%0d.count", i), 32'(cnt_a), 32'(vecs[i].cnt));
      check($sformatf("vec%0d.div",   i), 32'(div_a), 32'(vecs[i].div));
      check($sformatf("vec%0d.ovf",   i), 32'(ovf_a), 32'(vecs[i].ovf));
    end

    // Enable gap: 10 on, 5 off, then 6 more enabled edges to the first toggle.
    step(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1);
      check("gap.run.count", 32'(cnt_a), 32'(k));
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      check("gap.hold.count", 32'(cnt_a), 32'd10);
      check("gap.hold.div",   32'(div_a), 32'd0);
      check("gap.hold.ovf",   32'(ovf_a), 32'd0);
    end
    for (int k = 11; k <= 15; k++) begin
      step(1'b0, 1'b1);
      check("gap.resume.count", 32'(cnt_a), 32'(k));
      check("gap.resume.div",   32'(div_a), 32'd0);
    end
    step(1'b0, 1'b1);
    check("gap.wrap.count", 32'(cnt_a), 32'd0);
    check("gap.wrap.div",   32'(div_a), 32'd1);
    check("gap.wrap.ovf",   32'(ovf_a), 32'd1);
    step(1'b0, 1'b1);
    check("gap.post.count", 32'(cnt_a), 32'd1);
    check("gap.post.ovf",   32'(ovf_a), 32'd0);

    // Reset landing on count==15 with dividedClk high discards the pending wrap.
    step(1'b1, 1'b0);
    for (int k = 0; k < 31; k++) step(1'b0, 1'b1);
    check("rst15.pre.count", 32'(cnt_a), 32'd15);
    check("rst15.pre.div",   32'(div_a), 32'd1);
    step(1'b1, 1'b1);
    check("rst15.count", 32'(cnt_a), 32'd0);
    check("rst15.div",   32'(div_a), 32'd0);
    check("rst15.ovf",   32'(ovf_a), 32'd0);

    // Small instance: count 0..4 wrap, 5 high / 5 low.
    step(1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1);
      check("small.count", 32'(cnt_b), 32'(k % 5));
      check("small.div",   32'(div_b), 32'((k / 5) % 2));
      check("small.ovf",   32'(ovf_b), 32'(k % 5 == 0));
    end

    // Default instance steady-state high and low times (16 + 16 = 32 clk).
    step(1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1'b0, 1'b1);
      if (div_a) found = 1'b1;
    end
    check("period.first_rise_seen", 32'(found), 32'd1);
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1'b0, 1'b1);
      n++;
      if (!div_a) found = 1'b1;
    end
    check("period.high_cycles", 32'(n), 32'd16);
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1'b0, 1'b1);
      n++;
      if (div_a) found = 1'b1;
    end
    check("period.low_cycles", 32'(n), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
